flight_mode_filter: RTL

Parametrised flight-mode selector between the receiver decoder and the flight controller. Classifies the combined SWA/SWB receiver channel into one of NUM_BANDS bands, applies hysteresis and a consecutive-sample debounce before committing a mode, and reports each change with a pulse. Falls back to a failsafe mode when the receiver stops delivering samples. Replaces the single-cycle range decoder with a glitch-free, loss-of-signal-aware version.

---
 rtl/flight_mode_filter_pkg.sv | 40 ++++
 rtl/flight_mode_band_decode.sv | 62 ++++++
 rtl/flight_mode_filter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/flight_mode_filter_pkg.sv
// Shared encodings for the flight-mode selector: FSM states, switch codes
// and the band -> switch mapping used when a band is committed.
package flight_mode_filter_pkg;

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_LOCKED   = 2'd1;
    localparam logic [1:0] ST_FAILSAFE = 2'd2;

    localparam logic [2:0] SWA_OFF   = 3'b000;
    localparam logic [2:0] SWA_MODE0 = 3'b100;
    localparam logic [2:0] SWA_MODE1 = 3'b001;
    localparam logic [2:0] SWA_MODE2 = 3'b010;

    localparam logic [1:0] SWB_POS0 = 2'b00;
    localparam logic [1:0] SWB_POS1 = 2'b01;
    localparam logic [1:0] SWB_POS2 = 2'b10;
    localparam logic [1:0] SWB_POS3 = 2'b11;

    typedef struct packed {
        logic [2:0] swa;
        logic [1:0] swb;
    } mode_out_t;

    // Bands without a table entry map to all-off, even while locked.
    function automatic mode_out_t band_to_mode(input logic [2:0] band);
        mode_out_t m;
        m.swa = SWA_OFF;
        m.swb = SWB_POS0;
        case (band)
            3'd0: begin m.swa = SWA_MODE0; m.swb = SWB_POS1; end
            3'd1: begin m.swa = SWA_MODE0; m.swb = SWB_POS2; end
            3'd2: begin m.swa = SWA_MODE1; m.swb = SWB_POS3; end
            3'd3: begin m.swa = SWA_MODE2; m.swb = SWB_POS2; end
            3'd4: begin m.swa = SWA_MODE2; m.swb = SWB_POS1; end
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flight_mode_band_decode.sv
// Combinational band classifier. Produces the raw band of a receiver value
// and, when hysteresis is enabled, holds the committed band while the value
// stays inside the committed band widened by HYST on both sides.
module flight_mode_band_decode #(
    parameter int REC_W      = 8,
    parameter int NUM_BANDS  = 5,
    parameter int BAND_W     = 50,
    parameter int LAST_UPPER = 250,
    parameter int HYST       = 4
) (
    input  logic [REC_W-1:0] value,
    input  logic [2:0]       committed_band,
    input  logic             hyst_en,
    output logic [2:0]       band,
    output logic             in_range
);

    // Extra headroom so band bounds plus margin never wrap.
    localparam int EXT_W = REC_W + 4;
    localparam logic [EXT_W-1:0] BW_X    = EXT_W'(BAND_W);
    localparam logic [EXT_W-1:0] HYST_X  = EXT_W'(HYST);
    localparam logic [EXT_W-1:0] UPPER_X = EXT_W'(LAST_UPPER);
    localparam logic [2:0]       LAST_BAND = 3'(NUM_BANDS - 1);

    logic [EXT_W-1:0] val_ext;
    logic [EXT_W-1:0] base;
    logic [EXT_W-1:0] win_lo;
    logic [EXT_W-1:0] win_hi;
    logic [EXT_W-1:0] hi_raw;
    logic [2:0]       raw_band;

    assign val_ext  = EXT_W'(value);
    assign in_range = (val_ext <= UPPER_X);

    // Raw band: count band starts at or below the value; last band absorbs the rest.
    always_comb begin
        raw_band = '0;
        for (int k = 1; k < NUM_BANDS; k++) begin
            if (val_ext >= EXT_W'(k * BAND_W)) begin
                raw_band = 3'(k);
            end
        end
    end

    // Hysteresis window around the committed band, clamped to [0, LAST_UPPER].
    always_comb begin
        base   = EXT_W'(committed_band) * BW_X;
        win_lo = (base >= HYST_X) ? (base - HYST_X) : '0;
        hi_raw = base + BW_X - EXT_W'(1) + HYST_X;
        if (committed_band == LAST_BAND || hi_raw > UPPER_X) begin
            win_hi = UPPER_X;
        end else begin
            win_hi = hi_raw;
        end
        if (hyst_en && in_range && val_ext >= win_lo && val_ext <= win_hi) begin
            band = committed_band;
        end else begin
            band = raw_band;
        end
    end

endmodule

// File: rtl/flight_mode_filter.sv
// Flight-mode selector: debounces the classified receiver band, commits it to
// the switch outputs, unlocks on sustained out-of-range input and drops to
// failsafe when the receiver stops strobing.
//
//   state        | meaning
//   -------------+--------------------------------------------------------
//   ST_UNLOCKED  | no band committed, outputs off, debouncing candidates
//   ST_LOCKED    | band committed, hysteresis active around it
//   ST_FAILSAFE  | receiver silent for TIMEOUT_US cycles, outputs off
module flight_mode_filter
    import flight_mode_filter_pkg::*;
#(
    parameter int REC_W      = 8,
    parameter int NUM_BANDS  = 5,
    parameter int BAND_W     = 50,
    parameter int LAST_UPPER = 250,
    parameter int HYST       = 4,
    parameter int STABLE_N   = 8,
    parameter int TIMEOUT_US = 50000
) (
    input  logic             us_clk,
    input  logic             resetn,
    input  logic [REC_W-1:0] swa_swb_val,
    input  logic             val_strobe,
    output logic [2:0]       switch_a,
    output logic [1:0]       switch_b,
    output logic [2:0]       mode_idx,
    output logic             mode_locked,
    output logic             mode_changed,
    output logic             failsafe
);

    localparam int CNT_W = $clog2(STABLE_N + 1);
    localparam int TO_W  = $clog2(TIMEOUT_US + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_N);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_US);

    logic [1:0]       state, state_nx;
    logic [2:0]       cand_band, cand_nx;
    logic [CNT_W-1:0] stable_cnt, cnt_nx;
    logic [CNT_W-1:0] oor_cnt, oor_nx;
    logic [2:0]       commit_band, commit_nx;
    logic [TO_W-1:0]  to_cnt, to_nx;
    logic             timeout_hit;

    logic [2:0]       dec_band;
    logic             dec_in_range;

    logic             locked_nx;
    mode_out_t        mode_nx;
    logic [2:0]       swa_nx;
    logic [1:0]       swb_nx;
    logic [2:0]       idx_nx;
    logic             changed_nx;

    flight_mode_band_decode #(
        .REC_W      (REC_W),
        .NUM_BANDS  (NUM_BANDS),
        .BAND_W     (BAND_W),
        .LAST_UPPER (LAST_UPPER),
        .HYST       (HYST)
    ) u_band_decode (
        .value          (swa_swb_val),
        .committed_band (commit_band),
        .hyst_en        (state == ST_LOCKED),
        .band           (dec_band),
        .in_range       (dec_in_range)
    );

    assign timeout_hit = (to_cnt == TO_LIMIT);

    // Next-state: a strobe always beats a timeout expiring in the same cycle.
    always_comb begin
        state_nx  = state;
        cand_nx   = cand_band;
        cnt_nx    = stable_cnt;
        oor_nx    = oor_cnt;
        commit_nx = commit_band;
        if (val_strobe) begin
            if (state == ST_FAILSAFE) begin
                state_nx = ST_UNLOCKED;
            end
            if (!dec_in_range) begin
                cand_nx = '0;
                cnt_nx  = '0;
                oor_nx  = (oor_cnt == CNT_MAX) ? oor_cnt : oor_cnt + 1'b1;
                if (state == ST_LOCKED && oor_nx == CNT_MAX) begin
                    state_nx = ST_UNLOCKED;
                end
            end else begin
                oor_nx  = '0;
                cand_nx = dec_band;
                if (stable_cnt != '0 && dec_band == cand_band) begin
                    cnt_nx = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
                end else begin
                    cnt_nx = CNT_W'(1);
                end
                if (cnt_nx == CNT_MAX) begin
                    state_nx  = ST_LOCKED;
                    commit_nx = dec_band;
                end
            end
        end else if (timeout_hit) begin
            state_nx = ST_FAILSAFE;
            cand_nx  = '0;
            cnt_nx   = '0;
            oor_nx   = '0;
        end
    end

    // Silence timer restarts on every strobe and parks at the limit.
    always_comb begin
        if (val_strobe) begin
            to_nx = '0;
        end else if (timeout_hit) begin
            to_nx = to_cnt;
        end else begin
            to_nx = to_cnt + 1'b1;
        end
    end

    // Output values follow the next state so a commit shows one cycle after its strobe.
    always_comb begin
        locked_nx  = (state_nx == ST_LOCKED);
        mode_nx    = band_to_mode(commit_nx);
        swa_nx     = locked_nx ? mode_nx.swa : SWA_OFF;
        swb_nx     = locked_nx ? mode_nx.swb : SWB_POS0;
        idx_nx     = locked_nx ? commit_nx : 3'd0;
        changed_nx = ({swa_nx, swb_nx, locked_nx} != {switch_a, switch_b, mode_locked});
    end

    // FSM, debounce, out-of-range and timeout counters.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_UNLOCKED;
            cand_band   <= '0;
            stable_cnt  <= '0;
            oor_cnt     <= '0;
            commit_band <= '0;
            to_cnt      <= '0;
        end else begin
            state       <= state_nx;
            cand_band   <= cand_nx;
            stable_cnt  <= cnt_nx;
            oor_cnt     <= oor_nx;
            commit_band <= commit_nx;
            to_cnt      <= to_nx;
        end
    end

    // Registered outputs and the change pulse.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            switch_a     <= SWA_OFF;
            switch_b     <= SWB_POS0;
            mode_idx     <= '0;
            mode_locked  <= 1'b0;
            mode_changed <= 1'b0;
            failsafe     <= 1'b0;
        end else begin
            switch_a     <= swa_nx;
            switch_b     <= swb_nx;
            mode_idx     <= idx_nx;
            mode_locked  <= locked_nx;
            mode_changed <= changed_nx;
            failsafe     <= (state_nx == ST_FAILSAFE);
        end
    end

endmodule
